// File: rtl/imem_boot_loader.sv
// imem_boot_loader: length-prefixed byte stream to instruction memory writes; optional checksum via IMEM_BOOT_LOADER_CHECKSUM_EN
module imem_boot_loader #(
    parameter int ADDR_W = 6,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
`endif
    localparam logic [LEN_W:0] CAP = (LEN_W+1)'(2**ADDR_W);
    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, wcnt_q, wcnt_d, len_full;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              xfer;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif
    assign xfer       = in_valid & in_ready;
    assign len_full   = {len_q[LEN_W-1:8], in_data};
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign cpu_rst    = state_q != DONE;
    assign done       = state_q == DONE;
    assign error      = state_q == ERR;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    assign busy       = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA || state_q == CSUM;
`else
    assign busy       = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA;
`endif

    // Next-state and datapath: header capture, byte shifting, word write scheduling
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        bcnt_d   = bcnt_q;
        word_d   = word_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
        in_ready = ~rst & (state_q == LEN_HI || state_q == LEN_LO || state_q == CSUM ||
                           (state_q == DATA && wcnt_q != len_q));
`else
        in_ready = ~rst & (state_q == LEN_HI || state_q == LEN_LO ||
                           (state_q == DATA && wcnt_q != len_q));
`endif
        case (state_q)
            LEN_HI: if (xfer) begin
                len_d[LEN_W-1:8] = in_data;
                state_d          = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                len_d = len_full;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                state_d = len_full == '0 ? CSUM : ({1'b0, len_full} > CAP ? ERR : DATA);
`else
                state_d = len_full == '0 ? DONE : ({1'b0, len_full} > CAP ? ERR : DATA);
`endif
            end
            // wcnt == len means the last word's write strobe is out this cycle
            DATA: if (wcnt_q == len_q) begin
                state_d = DONE;
            end else if (xfer) begin
                word_d = {word_q[23:0], in_data};
                bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ in_data;
`endif
                if (bcnt_q == 2'd3) begin
                    we_d   = 1'b1;
                    addr_d = wcnt_q[ADDR_W-1:0];
                    wcnt_d = wcnt_q + 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                    if (wcnt_d == len_q) state_d = CSUM;
`endif
                end
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            CSUM: if (xfer) state_d = in_data == csum_q ? DONE : ERR;
`endif
            default: ;
        endcase
    end

    // State register with synchronous reset; memory contents are untouched by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LEN_HI;
            len_q   <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: scoreboard bench for imem_boot_loader; honours IMEM_BOOT_LOADER_CHECKSUM_EN
module tb_imem_boot_loader;
    localparam int AW = 6;
    logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready, imem_we, cpu_rst, busy, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    int            tests = 0, fails = 0;
    logic [AW+31:0] sb[$];
    logic [31:0]   dut_mem[64], exp_mem[64];
    logic [7:0]    data_q[$];
    bit            cpu_rst_p = 1'b1, we_p = 1'b0, chk_fall_we = 1'b0;

    imem_boot_loader #(.ADDR_W(AW), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes, mirrors the instruction memory, checks cpu_rst release timing
    always @(negedge clk) begin
        if (imem_we) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_we: got write addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = sb.pop_front();
                chk("we_addr", 32'(imem_addr), 32'(e[AW+31:32]));
                chk("we_data", imem_wdata, e[31:0]);
            end
            chk("we_cpu_rst", 32'(cpu_rst), 32'd1);
            dut_mem[imem_addr] = imem_wdata;
        end
        if (cpu_rst_p && !cpu_rst) begin
            chk("fall_no_we", 32'(imem_we), 32'd0);
            chk("fall_sb_empty", 32'(sb.size()), 32'd0);
            if (chk_fall_we) chk("fall_after_we", 32'(we_p), 32'd1);
        end
        cpu_rst_p = cpu_rst;
        we_p      = imem_we;
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk("gap_in_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready low for %0d cycles, required 1", n);
        end
        @(posedge clk);
    endtask

    task automatic fill_rand(input int nbytes);
        data_q.delete();
        for (int i = 0; i < nbytes; i++) data_q.push_back(8'($urandom));
    endtask

    task automatic finish_load(input bit exp_err);
        int n = 0, bad = -1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("end_done", 32'(done), 32'(!exp_err));
        chk("end_error", 32'(error), 32'(exp_err));
        chk("end_cpu_rst", 32'(cpu_rst), 32'(exp_err));
        chk("end_in_ready", 32'(in_ready), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);
        for (int i = 0; i < 64; i++) if (dut_mem[i] !== exp_mem[i]) bad = i;
        tests++;
        if (bad >= 0) begin
            fails++;
            $display("FAIL mem[%0d]: got %h expected %h", bad, dut_mem[bad], exp_mem[bad]);
        end
    endtask

    // Reference: header gives word count; >64 rejects; words are big-endian groups of data_q
    task automatic load(input int len, input int gmin, input int gmax, input bit bad);
        logic [7:0] cs = '0;
        bit exp_err = len > 64;
        if (!exp_err) for (int w = 0; w < len; w++) begin
            logic [31:0] word = {data_q[4*w], data_q[4*w+1], data_q[4*w+2], data_q[4*w+3]};
            sb.push_back({AW'(w), word});
            exp_mem[w] = word;
            cs = cs ^ data_q[4*w] ^ data_q[4*w+1] ^ data_q[4*w+2] ^ data_q[4*w+3];
        end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        exp_err = exp_err || bad;
        chk_fall_we = 1'b0;
`else
        chk_fall_we = len != 0;
`endif
        send_byte(8'(len >> 8), $urandom_range(gmax, gmin));
        send_byte(8'(len), $urandom_range(gmax, gmin));
        if (len <= 64) foreach (data_q[i]) send_byte(data_q[i], $urandom_range(gmax, gmin));
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        if (len <= 64) send_byte(cs ^ {7'd0, bad}, $urandom_range(gmax, gmin));
`endif
        finish_load(exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            dut_mem[i] = '0;
            exp_mem[i] = '0;
        end
        do_reset(2);
        data_q = '{8'h01, 8'h0A, 8'h48, 8'h20, 8'h01, 8'h09, 8'h50, 8'h22};
        load(2, 0, 0, 1'b0);
        do_reset(1);
        load(2, 3, 3, 1'b0);
        do_reset(1);
        data_q.delete();
        load(65, 0, 0, 1'b0);
        do_reset(1);
        fill_rand(256);
        load(64, 0, 1, 1'b0);
        do_reset(1);
        data_q.delete();
        load(0, 0, 1, 1'b0);
        do_reset(1);
        fill_rand(6);
        sb.push_back({AW'(0), data_q[0], data_q[1], data_q[2], data_q[3]});
        exp_mem[0] = {data_q[0], data_q[1], data_q[2], data_q[3]};
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        foreach (data_q[i]) send_byte(data_q[i], 0);
        do_reset(1);
        chk("midload_sb_empty", 32'(sb.size()), 32'd0);
        fill_rand(4);
        load(1, 0, 2, 1'b0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        do_reset(1);
        data_q = '{8'h8C, 8'h4A, 8'h00, 8'h00};
        load(1, 0, 0, 1'b0);
        do_reset(1);
        data_q = '{8'h8C, 8'h4A, 8'h00, 8'h00};
        load(1, 0, 0, 1'b1);
`endif
        for (int k = 0; k < 12; k++) begin
            int len = $urandom_range(64, 1);
            do_reset($urandom_range(2, 1));
            fill_rand(4 * len);
            load(len, 0, 2, ($urandom_range(3, 0) == 0));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
